// File: rtl/queue_param_fwft.sv
// -----------------------------------------------------------------------------
// queue_param_fwft
//
// Parametrised synchronous FIFO with first-word-fall-through output. It is a
// decoupling buffer for the ready/valid streaming path between convolution
// and packing stages. The storage is an inferred register array, so WIDTH and
// DEPTH are generic. DEPTH need not be a power of two. The FIFO also reports
// its occupancy, an almost-full flag and a high-water mark, and it supports a
// synchronous flush.
//
// Parameters:
//   WIDTH     data bits per entry
//   DEPTH     number of entries (>= 2, any integer)
//   AF_LEVEL  io_almost_full asserts when count >= AF_LEVEL (1..DEPTH)
//   CW        derived width of the count outputs, clog2(DEPTH+1)
//
// Ports:
//   clock           rising-edge clock for all state
//   reset           synchronous active-high reset (priority over flush)
//   io_enq_bits     write data
//   io_enq_valid    producer has data
//   io_enq_ready    registered; high when count < DEPTH
//   io_deq_bits     head-of-queue data, meaningful while io_deq_valid=1
//   io_deq_valid    high when count > 0
//   io_deq_ready    consumer accepts head
//   io_flush        synchronous clear of contents, pointers, count and max
//   io_count        current occupancy 0..DEPTH
//   io_almost_full  count >= AF_LEVEL
//   io_max_count    high-water mark of io_count since reset or flush
// -----------------------------------------------------------------------------
module queue_param_fwft #(
  parameter int WIDTH    = 1024,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 14,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] io_enq_bits,
  input  logic             io_enq_valid,
  output logic             io_enq_ready,
  output logic [WIDTH-1:0] io_deq_bits,
  output logic             io_deq_valid,
  input  logic             io_deq_ready,
  input  logic             io_flush,
  output logic [CW-1:0]    io_count,
  output logic             io_almost_full,
  output logic [CW-1:0]    io_max_count
);

  localparam int PW = $clog2(DEPTH);

  localparam logic [PW-1:0] PTR_ZERO = PW'(0);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_AF   = CW'(AF_LEVEL);

  // Pointer increment with explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    logic [PW-1:0] nxt;
    if (ptr == PTR_LAST) begin
      nxt = PTR_ZERO;
    end else begin
      nxt = ptr + PTR_ONE;
    end
    return nxt;
  endfunction

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] max_q, max_d;
  logic          enq_ready_q, enq_ready_d;

  logic deq_valid_s;
  logic enq_fire_s;
  logic deq_fire_s;
  logic mem_we_s;

  // Handshake decode; both ready and valid come only from registered state.
  always_comb begin
    deq_valid_s = (count_q != CNT_ZERO);
    enq_fire_s  = io_enq_valid & enq_ready_q;
    deq_fire_s  = deq_valid_s & io_deq_ready;
  end

  // Next-state for pointers, occupancy, high-water mark and enqueue ready.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    max_d       = max_q;
    enq_ready_d = enq_ready_q;
    mem_we_s    = 1'b0;

    if (io_flush) begin
      // Flush wins over any fire in the same cycle; that data is dropped.
      wr_ptr_d    = PTR_ZERO;
      rd_ptr_d    = PTR_ZERO;
      count_d     = CNT_ZERO;
      max_d       = CNT_ZERO;
      enq_ready_d = 1'b1;
    end else begin
      if (enq_fire_s) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
        mem_we_s = 1'b1;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end

      if (deq_fire_s) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end

      case ({enq_fire_s, deq_fire_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase

      if (count_d > max_q) begin
        max_d = count_d;
      end else begin
        max_d = max_q;
      end

      // Ready is a flop: a dequeue from full only reopens the next cycle.
      enq_ready_d = (count_d < CNT_FULL);
    end
  end

  // Control state register with synchronous reset taking priority.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q    <= PTR_ZERO;
      rd_ptr_q    <= PTR_ZERO;
      count_q     <= CNT_ZERO;
      max_q       <= CNT_ZERO;
      enq_ready_q <= 1'b1;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      max_q       <= max_d;
      enq_ready_q <= enq_ready_d;
    end
  end

  // Storage write port; contents are intentionally left uninitialised.
  always_ff @(posedge clock) begin
    if (mem_we_s && !reset) begin
      mem_q[wr_ptr_q] <= io_enq_bits;
    end
  end

  // Fall-through read: the head entry is always presented asynchronously.
  always_comb begin
    io_deq_bits    = mem_q[rd_ptr_q];
    io_deq_valid   = deq_valid_s;
    io_enq_ready   = enq_ready_q;
    io_count       = count_q;
    io_max_count   = max_q;
    io_almost_full = (count_q >= CNT_AF);
  end

  queue_param_fwft_chk #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_chk (
    .clock     (clock),
    .reset     (reset),
    .count     (count_q),
    .max_count (max_q),
    .deq_valid (deq_valid_s),
    .enq_ready (enq_ready_q)
  );

endmodule

// -----------------------------------------------------------------------------
// queue_param_fwft_chk
//
// Structural invariants of the FIFO control state. It observes the block and
// drives nothing.
//
// Ports:
//   clock, reset  as for the FIFO
//   count         occupancy register
//   max_count     high-water mark register
//   deq_valid     dequeue-valid decode
//   enq_ready     enqueue-ready flop
// -----------------------------------------------------------------------------
module queue_param_fwft_chk #(
  parameter int DEPTH = 16,
  parameter int CW    = 5
) (
  input logic          clock,
  input logic          reset,
  input logic [CW-1:0] count,
  input logic [CW-1:0] max_count,
  input logic          deq_valid,
  input logic          enq_ready
);

  a_count_bound: assert property (@(posedge clock) disable iff (reset)
    count <= CW'(DEPTH));

  a_deq_valid: assert property (@(posedge clock) disable iff (reset)
    deq_valid == (count != CW'(0)));

  a_enq_ready: assert property (@(posedge clock) disable iff (reset)
    enq_ready == (count < CW'(DEPTH)));

  a_max_bound: assert property (@(posedge clock) disable iff (reset)
    (max_count <= CW'(DEPTH)) && (max_count >= count));

endmodule

// File: tb/tb_queue_param_fwft.sv
module tb_queue_param_fwft;

  localparam int WA   = 1024;
  localparam int DA   = 16;
  localparam int AFA  = 14;
  localparam int CWA  = $clog2(DA + 1);
  localparam int WB   = 16;
  localparam int DB   = 5;
  localparam int AFB  = 3;
  localparam int CWB  = $clog2(DB + 1);

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Instance A: default geometry
  logic           reset_a;
  logic [WA-1:0]  enq_bits_a;
  logic           enq_valid_a, enq_ready_a;
  logic [WA-1:0]  deq_bits_a;
  logic           deq_valid_a, deq_ready_a;
  logic           flush_a;
  logic [CWA-1:0] count_a, max_a;
  logic           af_a;

  // Instance B: non-power-of-two depth
  logic           reset_b;
  logic [WB-1:0]  enq_bits_b;
  logic           enq_valid_b, enq_ready_b;
  logic [WB-1:0]  deq_bits_b;
  logic           deq_valid_b, deq_ready_b;
  logic           flush_b;
  logic [CWB-1:0] count_b, max_b;
  logic           af_b;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [WB-1:0] qb[$];
  int            maxb = 0;

  queue_param_fwft #(.WIDTH(WA), .DEPTH(DA), .AF_LEVEL(AFA)) dut_a (
    .clock(clock), .reset(reset_a),
    .io_enq_bits(enq_bits_a), .io_enq_valid(enq_valid_a), .io_enq_ready(enq_ready_a),
    .io_deq_bits(deq_bits_a), .io_deq_valid(deq_valid_a), .io_deq_ready(deq_ready_a),
    .io_flush(flush_a), .io_count(count_a), .io_almost_full(af_a), .io_max_count(max_a)
  );

  queue_param_fwft #(.WIDTH(WB), .DEPTH(DB), .AF_LEVEL(AFB)) dut_b (
    .clock(clock), .reset(reset_b),
    .io_enq_bits(enq_bits_b), .io_enq_valid(enq_valid_b), .io_enq_ready(enq_ready_b),
    .io_deq_bits(deq_bits_b), .io_deq_valid(deq_valid_b), .io_deq_ready(deq_ready_b),
    .io_flush(flush_b), .io_count(count_b), .io_almost_full(af_b), .io_max_count(max_b)
  );

  // Advance one clock: inputs change and outputs are sampled at the falling edge.
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  function automatic logic [WA-1:0] wa(input int v);
    logic [WA-1:0] r;
    r = '0;
    r[31:0] = 32'(v);
    return r;
  endfunction

  task automatic flush_a_once();
    flush_a = 1'b1;
    step();
    flush_a = 1'b0;
  endtask

  task automatic fill_a(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      enq_bits_a  = wa(base + i);
      enq_valid_a = 1'b1;
      step();
    end
    enq_valid_a = 1'b0;
  endtask

  task automatic test_reset();
    reset_a = 1'b1; reset_b = 1'b1;
    step(); step();
    n_cmp++; if (enq_ready_a !== 1'b1) begin n_fail++; $display("FAIL rst_enq_ready_a got %b want 1", enq_ready_a); end
    n_cmp++; if (deq_valid_a !== 1'b0) begin n_fail++; $display("FAIL rst_deq_valid_a got %b want 0", deq_valid_a); end
    n_cmp++; if (count_a !== CWA'(0)) begin n_fail++; $display("FAIL rst_count_a got %0d want 0", count_a); end
    n_cmp++; if (af_a !== 1'b0) begin n_fail++; $display("FAIL rst_af_a got %b want 0", af_a); end
    n_cmp++; if (max_a !== CWA'(0)) begin n_fail++; $display("FAIL rst_max_a got %0d want 0", max_a); end
    n_cmp++; if (count_b !== CWB'(0) || deq_valid_b !== 1'b0 || enq_ready_b !== 1'b1) begin
      n_fail++; $display("FAIL rst_b got cnt=%0d dv=%b er=%b want 0/0/1", count_b, deq_valid_b, enq_ready_b);
    end
    reset_a = 1'b0; reset_b = 1'b0;
    step();
  endtask

  task automatic test_enq_latency();
    enq_bits_a = wa(32'hA5); enq_valid_a = 1'b1; deq_ready_a = 1'b0;
    n_cmp++; if (deq_valid_a !== 1'b0) begin n_fail++; $display("FAIL lat_no_bypass got %b want 0", deq_valid_a); end
    step();
    enq_valid_a = 1'b0;
    n_cmp++; if (deq_valid_a !== 1'b1) begin n_fail++; $display("FAIL lat_deq_valid got %b want 1", deq_valid_a); end
    n_cmp++; if (deq_bits_a !== wa(32'hA5)) begin n_fail++; $display("FAIL lat_bits got %0h want a5", deq_bits_a); end
    n_cmp++; if (count_a !== CWA'(1)) begin n_fail++; $display("FAIL lat_count got %0d want 1", count_a); end
    n_cmp++; if (max_a !== CWA'(1)) begin n_fail++; $display("FAIL lat_max got %0d want 1", max_a); end
    step();
    n_cmp++; if (deq_bits_a !== wa(32'hA5)) begin n_fail++; $display("FAIL lat_stable got %0h want a5", deq_bits_a); end
    flush_a_once();
  endtask

  task automatic test_fill_drain();
    deq_ready_a = 1'b0;
    for (int i = 0; i < DA; i++) begin
      enq_bits_a = wa(i); enq_valid_a = 1'b1;
      step();
      n_cmp++; if (count_a !== CWA'(i + 1)) begin n_fail++; $display("FAIL fill_count got %0d want %0d", count_a, i + 1); end
      n_cmp++; if (af_a !== ((i + 1) >= AFA)) begin n_fail++; $display("FAIL fill_af at %0d got %b", i + 1, af_a); end
      n_cmp++; if (enq_ready_a !== ((i + 1) < DA)) begin n_fail++; $display("FAIL fill_ready at %0d got %b", i + 1, enq_ready_a); end
    end
    enq_bits_a = wa(99); enq_valid_a = 1'b1;
    step();
    enq_valid_a = 1'b0;
    n_cmp++; if (count_a !== CWA'(DA)) begin n_fail++; $display("FAIL extra_enq_count got %0d want %0d", count_a, DA); end
    deq_ready_a = 1'b1;
    for (int i = 0; i < DA; i++) begin
      n_cmp++; if (deq_valid_a !== 1'b1 || deq_bits_a !== wa(i)) begin
        n_fail++; $display("FAIL drain_order got v=%b d=%0h want 1/%0h", deq_valid_a, deq_bits_a[31:0], i);
      end
      step();
    end
    deq_ready_a = 1'b0;
    n_cmp++; if (deq_valid_a !== 1'b0 || count_a !== CWA'(0)) begin n_fail++; $display("FAIL drain_empty got v=%b c=%0d want 0/0", deq_valid_a, count_a); end
    n_cmp++; if (max_a !== CWA'(DA)) begin n_fail++; $display("FAIL drain_max got %0d want %0d", max_a, DA); end
    flush_a_once();
  endtask

  task automatic test_full_simul();
    fill_a(DA, 100);
    n_cmp++; if (enq_ready_a !== 1'b0) begin n_fail++; $display("FAIL full_ready got %b want 0", enq_ready_a); end
    enq_bits_a = wa(32'h77); enq_valid_a = 1'b1; deq_ready_a = 1'b1;
    n_cmp++; if (deq_bits_a !== wa(100)) begin n_fail++; $display("FAIL full_head got %0h want 64", deq_bits_a[31:0]); end
    step();
    enq_valid_a = 1'b0; deq_ready_a = 1'b0;
    n_cmp++; if (count_a !== CWA'(DA - 1)) begin n_fail++; $display("FAIL full_simul_count got %0d want %0d", count_a, DA - 1); end
    n_cmp++; if (enq_ready_a !== 1'b1) begin n_fail++; $display("FAIL full_simul_ready got %b want 1", enq_ready_a); end
    deq_ready_a = 1'b1;
    for (int i = 1; i < DA; i++) begin
      n_cmp++; if (deq_bits_a !== wa(100 + i)) begin n_fail++; $display("FAIL full_drain got %0h want %0h", deq_bits_a[31:0], 100 + i); end
      step();
    end
    deq_ready_a = 1'b0;
    n_cmp++; if (deq_valid_a !== 1'b0) begin n_fail++; $display("FAIL full_drain_empty got %b want 0", deq_valid_a); end
    flush_a_once();
  endtask

  task automatic test_back_to_back();
    int mq[$];
    fill_a(8, 200);
    for (int i = 0; i < 8; i++) mq.push_back(200 + i);
    for (int k = 0; k < 40; k++) begin
      enq_bits_a = wa(300 + k); enq_valid_a = 1'b1; deq_ready_a = 1'b1;
      n_cmp++; if (deq_bits_a !== wa(mq[0]) || count_a !== CWA'(8)) begin
        n_fail++; $display("FAIL b2b got d=%0h c=%0d want %0h/8", deq_bits_a[31:0], count_a, mq[0]);
      end
      void'(mq.pop_front());
      mq.push_back(300 + k);
      step();
    end
    enq_valid_a = 1'b0; deq_ready_a = 1'b0;
    n_cmp++; if (count_a !== CWA'(8)) begin n_fail++; $display("FAIL b2b_count got %0d want 8", count_a); end
    n_cmp++; if (max_a !== CWA'(8)) begin n_fail++; $display("FAIL b2b_max got %0d want 8", max_a); end
    n_cmp++; if (deq_bits_a !== wa(mq[0])) begin n_fail++; $display("FAIL b2b_head got %0h want %0h", deq_bits_a[31:0], mq[0]); end
    flush_a_once();
  endtask

  task automatic test_flush();
    fill_a(5, 400);
    enq_bits_a = wa(32'h999); enq_valid_a = 1'b1; deq_ready_a = 1'b1; flush_a = 1'b1;
    step();
    enq_valid_a = 1'b0; deq_ready_a = 1'b0; flush_a = 1'b0;
    n_cmp++; if (count_a !== CWA'(0)) begin n_fail++; $display("FAIL flush_count got %0d want 0", count_a); end
    n_cmp++; if (deq_valid_a !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b want 0", deq_valid_a); end
    n_cmp++; if (max_a !== CWA'(0)) begin n_fail++; $display("FAIL flush_max got %0d want 0", max_a); end
    n_cmp++; if (enq_ready_a !== 1'b1) begin n_fail++; $display("FAIL flush_ready got %b want 1", enq_ready_a); end
    enq_bits_a = wa(32'h55); enq_valid_a = 1'b1;
    step();
    enq_valid_a = 1'b0;
    step();
    n_cmp++; if (deq_bits_a !== wa(32'h55) || count_a !== CWA'(1)) begin
      n_fail++; $display("FAIL flush_after got d=%0h c=%0d want 55/1", deq_bits_a[31:0], count_a);
    end
    flush_a_once();
  endtask

  task automatic check_b();
    n_cmp++; if (count_b !== CWB'(qb.size())) begin n_fail++; $display("FAIL rnd_count got %0d want %0d", count_b, qb.size()); end
    n_cmp++; if (deq_valid_b !== (qb.size() > 0)) begin n_fail++; $display("FAIL rnd_valid got %b want %0d", deq_valid_b, qb.size() > 0); end
    n_cmp++; if (enq_ready_b !== (qb.size() < DB)) begin n_fail++; $display("FAIL rnd_ready got %b", enq_ready_b); end
    n_cmp++; if (af_b !== (qb.size() >= AFB)) begin n_fail++; $display("FAIL rnd_af got %b size %0d", af_b, qb.size()); end
    n_cmp++; if (max_b !== CWB'(maxb)) begin n_fail++; $display("FAIL rnd_max got %0d want %0d", max_b, maxb); end
    n_cmp++; if (count_b > CWB'(DB)) begin n_fail++; $display("FAIL rnd_bound got %0d want <=%0d", count_b, DB); end
    if (qb.size() > 0) begin
      n_cmp++; if (deq_bits_b !== qb[0]) begin n_fail++; $display("FAIL rnd_data got %0h want %0h", deq_bits_b, qb[0]); end
    end
  endtask

  task automatic model_b();
    bit ef, df;
    if (flush_b) begin
      qb.delete();
      maxb = 0;
    end else begin
      ef = enq_valid_b && (qb.size() < DB);
      df = deq_ready_b && (qb.size() > 0);
      if (df) void'(qb.pop_front());
      if (ef) qb.push_back(enq_bits_b);
      if (qb.size() > maxb) maxb = qb.size();
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 2000; n++) begin
      check_b();
      enq_valid_b = 1'($urandom_range(0, 1));
      deq_ready_b = 1'($urandom_range(0, 1));
      enq_bits_b  = WB'($urandom);
      flush_b     = ($urandom_range(0, 49) == 0);
      model_b();
      step();
    end
    flush_b = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    deq_ready_b = 1'b0; flush_b = 1'b0;
    for (int n = 0; n < 3; n++) begin
      enq_valid_b = 1'b1; enq_bits_b = WB'($urandom);
      model_b();
      step();
    end
    check_b();
    n_cmp++; if (count_b === CWB'(0)) begin n_fail++; $display("FAIL burst_nonempty got %0d want >0", count_b); end
    reset_b = 1'b1; enq_valid_b = 1'b1; deq_ready_b = 1'b1;
    step();
    reset_b = 1'b0; enq_valid_b = 1'b0; deq_ready_b = 1'b0;
    n_cmp++; if (count_b !== CWB'(0) || deq_valid_b !== 1'b0) begin n_fail++; $display("FAIL midrst got c=%0d v=%b want 0/0", count_b, deq_valid_b); end
    n_cmp++; if (max_b !== CWB'(0) || enq_ready_b !== 1'b1) begin n_fail++; $display("FAIL midrst2 got m=%0d r=%b want 0/1", max_b, enq_ready_b); end
  endtask

  initial begin
    reset_a = 1'b1; enq_bits_a = '0; enq_valid_a = 1'b0; deq_ready_a = 1'b0; flush_a = 1'b0;
    reset_b = 1'b1; enq_bits_b = '0; enq_valid_b = 1'b0; deq_ready_b = 1'b0; flush_b = 1'b0;
    @(negedge clock);
    test_reset();
    test_enq_latency();
    test_fill_drain();
    test_full_simul();
    test_back_to_back();
    test_flush();
    test_random();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
